// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, ALU selects and
// the controller state and ALU-class enums.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSrl  = 4'd3;
  localparam logic [3:0] AluSllv = 4'd4;
  localparam logic [3:0] AluSrlv = 4'd5;
  localparam logic [3:0] AluSra  = 4'd6;
  localparam logic [3:0] AluAnd  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluXor  = 4'd9;
  localparam logic [3:0] AluSrav = 4'd11;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StRtExe, StRtWb, StIExe, StIWb, StBranch, StJump, StTrap
  } state_e;

  typedef enum logic [2:0] {
    AluClsNone, AluClsAdd, AluClsSub, AluClsFunct, AluClsImm
  } alu_cls_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU select decode from (state class, opcode, funct), plus R-type
// legality and whether the instruction traps on signed overflow.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_cls_e    alu_cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_sel,
  output logic        rtype_legal,
  output logic        trap_on_ovf
);

  logic [3:0] funct_sel;
  logic [3:0] imm_sel;

  always_comb begin
    funct_sel   = AluAdd;
    rtype_legal = 1'b1;
    case (funct)
      FnAdd, FnAddu: funct_sel = AluAdd;
      FnSub, FnSubu: funct_sel = AluSub;
      FnSll:         funct_sel = AluSll;
      FnSrl:         funct_sel = AluSrl;
      FnSra:         funct_sel = AluSra;
      FnSllv:        funct_sel = AluSllv;
      FnSrlv:        funct_sel = AluSrlv;
      FnSrav:        funct_sel = AluSrav;
      FnAnd:         funct_sel = AluAnd;
      FnOr:          funct_sel = AluOr;
      FnXor:         funct_sel = AluXor;
      default:       rtype_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_sel = AluAdd;
    case (opcode)
      OpAndi:  imm_sel = AluAnd;
      OpOri:   imm_sel = AluOr;
      OpXori:  imm_sel = AluXor;
      default: imm_sel = AluAdd;
    endcase
  end

  // Only the signed add/sub forms trap; addu/subu wrap silently.
  assign trap_on_ovf = ((opcode == OpRtype) && ((funct == FnAdd) || (funct == FnSub))) ||
                       (opcode == OpAddi);

  always_comb begin
    alu_sel = AluAdd;
    case (alu_cls)
      AluClsAdd:   alu_sel = AluAdd;
      AluClsSub:   alu_sel = AluSub;
      AluClsFunct: alu_sel = funct_sel;
      AluClsImm:   alu_sel = imm_sel;
      default:     alu_sel = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback sequencing with overflow and illegal-instruction traps.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int unsigned SEL_BITS    = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                ovf,
  input  logic                mem_ready,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                imm_zext,
  output logic [SEL_BITS-1:0] alu_sel,
  output logic                exc_ovf,
  output logic                exc_ill
);

  state_e   state_q, state_d;
  logic     cause_ovf_q, cause_ovf_d;
  alu_cls_e alu_cls;
  logic [3:0] dec_sel;
  logic     rtype_legal;
  logic     trap_on_ovf;
  logic     mem_rdy;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  mips_alu_decoder u_alu_decoder (
    .alu_cls     (alu_cls),
    .opcode      (opcode),
    .funct       (funct),
    .alu_sel     (dec_sel),
    .rtype_legal (rtype_legal),
    .trap_on_ovf (trap_on_ovf)
  );

  assign alu_sel = SEL_BITS'(dec_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRst;
      cause_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_ovf_q <= cause_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_ovf_d = cause_ovf_q;
    alu_cls     = AluClsNone;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'd0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    imm_zext    = 1'b0;
    exc_ovf     = 1'b0;
    exc_ill     = 1'b0;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        alu_src_b = 2'd1;
        alu_cls   = AluClsAdd;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'd3;
        alu_cls   = AluClsAdd;
        case (opcode)
          OpLw, OpSw:                   state_d = StMemAdr;
          OpRtype:                      state_d = rtype_legal ? StRtExe : StTrap;
          OpAddi, OpAndi, OpOri, OpXori: state_d = StIExe;
          OpBeq, OpBne:                 state_d = StBranch;
          OpJ:                          state_d = StJump;
          default:                      state_d = StTrap;
        endcase
        cause_ovf_d = 1'b0;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_cls   = AluClsAdd;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord = 1'b1;
        if (mem_rdy) state_d = StMemWb;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) state_d = StFetch;
      end
      StRtExe: begin
        alu_src_a = 1'b1;
        alu_cls   = AluClsFunct;
        if (ovf && trap_on_ovf) begin
          state_d     = StTrap;
          cause_ovf_d = 1'b1;
        end else begin
          state_d = StRtWb;
        end
      end
      StRtWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StIExe: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_cls   = AluClsImm;
        imm_zext  = (opcode == OpAndi) || (opcode == OpOri) || (opcode == OpXori);
        if (ovf && trap_on_ovf) begin
          state_d     = StTrap;
          cause_ovf_d = 1'b1;
        end else begin
          state_d = StIWb;
        end
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_cls   = AluClsSub;
        pc_src    = 2'd1;
        pc_en     = (opcode == OpBne) ? !zero : zero;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src  = 2'd2;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StTrap: begin
        exc_ovf = cause_ovf_q;
        exc_ill = !cause_ovf_q;
        state_d = StFetch;
      end
      default: state_d = StRst;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller: each instruction is expanded into an
// expected per-cycle output trace from the instruction-level rules, then replayed.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, ovf, mem_ready;
  logic       iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, imm_zext, exc_ovf, exc_ill;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_sel;

  always #5 clk = ~clk;

  mips_mc_controller #(.SEL_BITS(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .ovf(ovf),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_sel(alu_sel), .exc_ovf(exc_ovf), .exc_ill(exc_ill)
  );

  typedef struct packed {
    logic       iord, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_sel;
    logic       exc_ovf, exc_ill;
  } outs_t;

  typedef struct packed {
    logic       rst, mr, ovf, zero;
    logic [5:0] op, fn;
    outs_t      o;
  } step_t;

  step_t       step_q[$];
  string       tag_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          fsel[int];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o.iord = iord; o.mem_write = mem_write; o.ir_write = ir_write; o.pc_en = pc_en;
    o.pc_src = pc_src; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.reg_write = reg_write; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.imm_zext = imm_zext; o.alu_sel = alu_sel; o.exc_ovf = exc_ovf; o.exc_ill = exc_ill;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input string tag, input outs_t o, input logic r, input logic mr,
                      input logic ov, input logic z, input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.rst = r; s.mr = mr; s.ovf = ov; s.zero = z; s.op = op; s.fn = fn; s.o = o;
    step_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  // Expected trace for one instruction; fw/mw are mem_ready-low cycles in fetch/memory.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic eovf, input logic bz, input bit rst_wait);
    outs_t o;
    bit    is_sw = (op == 6'h2B);
    for (int i = 0; i < fw; i++) begin
      o = '0; o.alu_src_b = 2'd1;
      push("fetch_wait", o, 0, 0, rb(), rb(), 6'($urandom), 6'($urandom));
    end
    o = '0; o.alu_src_b = 2'd1; o.ir_write = 1; o.pc_en = 1;
    push("fetch", o, 0, 1, rb(), rb(), 6'($urandom), 6'($urandom));
    o = '0; o.alu_src_b = 2'd3;
    push("decode", o, 0, rb(), rb(), rb(), op, fn);
    if (op == 6'h23 || is_sw) begin
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2;
      push("memadr", o, 0, rb(), rb(), rb(), op, fn);
      o = '0; o.iord = 1; o.mem_write = is_sw;
      for (int i = 0; i < mw; i++) begin
        push(is_sw ? "memwr_wait" : "memrd_wait", o, rst_wait, 0, rb(), rb(), op, fn);
        if (rst_wait) begin
          push("after_rst", '0, 0, rb(), rb(), rb(), op, fn);
          return;
        end
      end
      push(is_sw ? "memwr" : "memrd", o, 0, 1, rb(), rb(), op, fn);
      if (!is_sw) begin
        o = '0; o.mem_to_reg = 1; o.reg_write = 1;
        push("memwb", o, 0, rb(), rb(), rb(), op, fn);
      end
    end else if (op == 6'h00 && fsel.exists(int'(fn))) begin
      o = '0; o.alu_src_a = 1; o.alu_sel = 4'(fsel[int'(fn)]);
      push("rtexe", o, 0, rb(), eovf, rb(), op, fn);
      o = '0;
      if (eovf && (fn == 6'h20 || fn == 6'h22)) begin
        o.exc_ovf = 1; push("trap_ovf", o, 0, rb(), rb(), rb(), op, fn);
      end else begin
        o.reg_dst = 1; o.reg_write = 1; push("rtwb", o, 0, rb(), rb(), rb(), op, fn);
      end
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.imm_zext = (op != 6'h08);
      o.alu_sel = (op == 6'h0C) ? 4'd7 : (op == 6'h0D) ? 4'd8 : (op == 6'h0E) ? 4'd9 : 4'd0;
      push("iexe", o, 0, rb(), eovf, rb(), op, fn);
      o = '0;
      if (eovf && op == 6'h08) begin
        o.exc_ovf = 1; push("trap_ovf", o, 0, rb(), rb(), rb(), op, fn);
      end else begin
        o.reg_write = 1; push("iwb", o, 0, rb(), rb(), rb(), op, fn);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = '0; o.alu_src_a = 1; o.alu_sel = 4'd1; o.pc_src = 2'd1;
      o.pc_en = (op == 6'h04) ? bz : !bz;
      push("branch", o, 0, rb(), rb(), bz, op, fn);
    end else if (op == 6'h02) begin
      o = '0; o.pc_src = 2'd2; o.pc_en = 1;
      push("jump", o, 0, rb(), rb(), rb(), op, fn);
    end else begin
      o = '0; o.exc_ill = 1;
      push("trap_ill", o, 0, rb(), rb(), rb(), op, fn);
    end
  endtask

  task automatic run_steps();
    step_t s;
    string t;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      t = tag_q.pop_front();
      @(negedge clk);
      rst = s.rst; mem_ready = s.mr; ovf = s.ovf; zero = s.zero;
      opcode = s.op; funct = s.fn;
      #1;
      check_eq(t, 32'(dut_outs()), 32'(s.o));
    end
  endtask

  logic [5:0] ops [13];
  logic [5:0] fns [13];

  initial begin
    fsel[32'h20] = 0; fsel[32'h21] = 0; fsel[32'h22] = 1; fsel[32'h23] = 1;
    fsel[32'h00] = 2; fsel[32'h02] = 3; fsel[32'h03] = 6; fsel[32'h04] = 4;
    fsel[32'h06] = 5; fsel[32'h07] = 11; fsel[32'h24] = 7; fsel[32'h25] = 8;
    fsel[32'h26] = 9;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E,
            6'h23, 6'h2B, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h24, 6'h25, 6'h27};

    rst = 1; mem_ready = 1; ovf = 0; zero = 0; opcode = '0; funct = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) push("reset", '0, 1, 1, rb(), rb(), 6'($urandom), 6'($urandom));
    push("rst_exit", '0, 0, 1, rb(), rb(), 6'($urandom), 6'($urandom));

    add_instr(6'h23, 6'h00, 0, 2, 0, 0, 0);  // lw, two memory wait cycles
    add_instr(6'h00, 6'h20, 0, 0, 1, 0, 0);  // add overflow trap
    add_instr(6'h00, 6'h21, 0, 0, 1, 0, 0);  // addu ignores overflow
    add_instr(6'h04, 6'h00, 0, 0, 0, 1, 0);
    add_instr(6'h05, 6'h00, 0, 0, 0, 1, 0);
    add_instr(6'h00, 6'h00, 0, 0, 0, 0, 0);
    add_instr(6'h00, 6'h07, 0, 0, 0, 0, 0);
    add_instr(6'h00, 6'h25, 0, 0, 0, 0, 0);
    add_instr(6'h00, 6'h27, 0, 0, 0, 0, 0);  // illegal funct
    add_instr(6'h08, 6'h00, 1, 0, 1, 0, 0);  // addi overflow trap
    add_instr(6'h2B, 6'h00, 0, 1, 0, 0, 1);  // sw, reset during memory wait
    add_instr(6'h2B, 6'h00, 2, 2, 0, 0, 0);
    run_steps();

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 12)];
      if (op == 6'h3F) op = 6'($urandom);
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
      add_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb(), 0);
      run_steps();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the 4-bit ALU select and its operand muxes, and consumes the ALU zero and overflow flags. Sits beside the datapath at top level, one instance per core.

Parameters:
SEL_BITS, 4, width of ALU select; must match ALU selBits.
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored, one cycle each.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from IR
funct  input  6  instr[5:0] from IR
zero  input  1  ALU zero flag
ovf  input  1  ALU overflow flag
mem_ready  input  1  memory completes access this cycle
iord  output  1  0 = PC addresses memory, 1 = ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  load IR
pc_en  output  1  PC write enable (after branch qualification)
pc_src  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = memory data
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm << 2
imm_zext  output  1  1 = zero-extend immediate (andi/ori/xori)
alu_sel  output  SEL_BITS  ALU operation select
exc_ovf  output  1  one-cycle pulse: overflow trap, writeback suppressed
exc_ill  output  1  one-cycle pulse: illegal opcode/funct

Behaviour:
- Moore FSM; all outputs decode from the state register plus opcode/funct. pc_en is the only output that also uses zero.
- States:
  - S_RST: entered on rst; all outputs 0.
  - S_FETCH: iord=0, ir_write, src_a=0, src_b=1, sel=ADD, pc_en=1, pc_src=0. pc_en/ir_write are asserted only in the cycle mem_ready=1. Otherwise hold with strobes low.
  - S_DECODE: src_a=0, src_b=3, sel=ADD (branch target into ALUOut).
  - S_MEMADR: src_a=1, src_b=2, sel=ADD.
  - S_MEMRD: iord=1; waits on mem_ready.
  - S_MEMWB: reg_dst=0, mem_to_reg=1, reg_write.
  - S_MEMWR: iord=1, mem_write; waits on mem_ready; mem_write stays high while waiting.
  - S_RTEXE: src_a=1, src_b=0, sel from funct.
  - S_RTWB: reg_dst=1, reg_write.
  - S_IEXE: src_a=1, src_b=2, imm_zext per opcode.
  - S_IWB: reg_dst=0, reg_write.
  - S_BRANCH: src_a=1, src_b=0, sel=SUB, pc_src=1, pc_en = zero (beq) or !zero (bne).
  - S_JUMP: pc_src=2, pc_en.
  - S_TRAP: exc_ovf=1 or exc_ill=1.
- Transitions:
  - S_RST -> S_FETCH.
  - S_FETCH -> S_DECODE on mem_ready.
  - S_DECODE dispatch: lw(0x23)/sw(0x2B) -> S_MEMADR; R(0x00) with legal funct -> S_RTEXE; addi(0x08)/andi(0x0C)/ori(0x0D)/xori(0x0E) -> S_IEXE; beq(0x04)/bne(0x05) -> S_BRANCH; j(0x02) -> S_JUMP; anything else -> S_TRAP (ill).
  - S_MEMADR -> S_MEMRD (lw) or S_MEMWR (sw).
  - S_MEMRD -> S_MEMWB on mem_ready.
  - S_MEMWR -> S_FETCH on mem_ready.
  - S_RTEXE -> S_TRAP (ovf) if ovf and funct is add/sub; else -> S_RTWB.
  - S_IEXE -> S_TRAP (ovf) if ovf and opcode is addi; else -> S_IWB.
  - addu/subu ignore ovf.
  - All writeback, branch, jump and trap states -> S_FETCH.
- Overflow is sampled in the execute state only. It is latched into a 1-bit trap-cause flop used by S_TRAP.
- funct -> sel:
  - 0x20/0x21 -> 0 (add)
  - 0x22/0x23 -> 1 (sub)
  - 0x00 -> 2 (sll)
  - 0x02 -> 3 (srl)
  - 0x03 -> 6 (sra)
  - 0x04 -> 4 (sllv)
  - 0x06 -> 5 (srlv)
  - 0x07 -> 11 (srav)
  - 0x24 -> 7 (and)
  - 0x25 -> 8 (or)
  - 0x26 -> 9 (xor)
  - other funct -> illegal.
- Opcode -> sel: addi 0, andi 7, ori 8, xori 9.
- In states where the ALU is unused, alu_sel = 0.
- rst has priority over all transitions. Asserting rst mid-instruction (including during a memory wait) returns to S_RST the next edge. The next edge clears every strobe, so no partial write escapes.
- Latency: lw 5 cycles, sw/R/I-type 4, beq/bne/j 3, each with zero memory wait. Each mem_ready-low cycle adds 1 in S_FETCH, S_MEMRD and S_MEMWR.
- With MEM_WAIT_EN=0, mem_ready is treated as constant 1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants
  - funct constants
  - ALU select constants (values 0-11 as above)
  - state enum encoding
- The datapath imports mips_pkg for the same ALU select constants.
- One sub-module: mips_alu_decoder. It is combinational and maps (state class, opcode, funct) to alu_sel, an rtype_legal flag and a trap_on_ovf flag.

Test Plan:
- rst held 3 cycles then released, mem_ready=1 -> all outputs 0 during rst; S_FETCH on the first post-reset cycle with pc_en=1, ir_write=1, alu_sel=0, alu_src_b=1.
- lw (opcode 0x23), mem_ready low 2 cycles in S_MEMRD -> 7-cycle instruction; reg_write=1 with mem_to_reg=1 exactly once; iord=1 only in S_MEMRD.
- R-type add (funct 0x20) with ovf=1 in execute -> exc_ovf pulses 1 cycle; reg_write never asserted. Repeat with addu (0x21) -> reg_write=1 in S_RTWB, no trap.
- beq (0x04) with zero=1 -> pc_en=1, pc_src=1 in S_BRANCH. bne (0x05) with zero=1 -> pc_en=0. Both return to S_FETCH after 3 cycles.
- funct sweep: sll 0x00 -> sel 2, srav 0x07 -> sel 11, or 0x25 -> sel 8. Undefined funct 0x27 -> exc_ill=1 in cycle 3, no reg_write.
- sw with mem_ready low, rst asserted in the wait cycle -> mem_write=0 on the next edge, FSM in S_RST, then S_FETCH.
